// File: rtl/i2s_pkg.sv
// Shared I2S definitions: word-select encoding, default geometry and the
// slot-counter width helper used by the transmitter and the frame timer.
package i2s_pkg;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  localparam int DEFAULT_NUMBER_OF_BITS = 8;
  localparam int DEFAULT_SLOT_BITS      = 32;

  // Bits needed to count 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pcm_to_i2s_tx_if.sv
// Parallel PCM sample-pair handshake between a producer (DSP path) and the
// I2S transmitter. master = producer side, slave = transmitter side.
interface pcm_to_i2s_tx_if
  import i2s_pkg::*;
#(
  parameter int NUMBER_OF_BITS = DEFAULT_NUMBER_OF_BITS
) ();

  logic [NUMBER_OF_BITS-1:0] pcm_left;
  logic [NUMBER_OF_BITS-1:0] pcm_right;
  logic                      pcm_valid;
  logic                      pcm_ready;

  modport master (
    output pcm_left,
    output pcm_right,
    output pcm_valid,
    input  pcm_ready
  );

  modport slave (
    input  pcm_left,
    input  pcm_right,
    input  pcm_valid,
    output pcm_ready
  );

endinterface

// File: rtl/i2s_frame_timer.sv
// I2S frame timer: slot counter, word select, frame_start pulse and the frame
// load strobes. Shared between the transmitter and the receiver bench.
// load fires in the last right-slot cycle; load_ahead fires one cycle earlier
// so registered flags can be visible during the load cycle itself.
module i2s_frame_timer
  import i2s_pkg::*;
#(
  parameter int SLOT_BITS = DEFAULT_SLOT_BITS,
  parameter int KW        = clog2(SLOT_BITS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ena,
  output logic [KW-1:0] slot_k_next,
  output logic          ws_out,
  output logic          ws_out_next,
  output logic          frame_start,
  output logic          load,
  output logic          load_ahead
);

  localparam logic [KW-1:0] LAST_K = KW'(SLOT_BITS - 1);

  logic [KW-1:0] k_reg;
  logic [KW-1:0] k_next;
  logic          ws_reg;
  logic          ws_next;
  logic          frame_start_reg;

  // Advance the slot counter while enabled; wrap and flip WS at the slot end.
  always_comb begin
    k_next  = k_reg;
    ws_next = ws_reg;
    if (ena) begin
      if (k_reg == LAST_K) begin
        k_next  = '0;
        ws_next = ~ws_reg;
      end else begin
        k_next = k_reg + 1'b1;
      end
    end
  end

  assign load       = ena && (k_reg == LAST_K) && (ws_reg == WS_RIGHT);
  assign load_ahead = ena && (k_next == LAST_K) && (ws_next == WS_RIGHT);

  // Timer state; frame_start follows the load edge, i.e. left slot k=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_reg           <= '0;
      ws_reg          <= WS_LEFT;
      frame_start_reg <= 1'b0;
    end else begin
      k_reg           <= k_next;
      ws_reg          <= ws_next;
      frame_start_reg <= load;
    end
  end

  assign slot_k_next = k_next;
  assign ws_out      = ws_reg;
  assign ws_out_next = ws_next;
  assign frame_start = frame_start_reg;

endmodule

// File: rtl/pcm_to_i2s_tx.sv
// Parallel PCM to I2S serializer (master, clk is the bit clock).
// A holding register decouples the producer handshake from the frame
// register, which is reloaded once per frame at the end of the right slot.
// Optional feature macro: PCM_TO_I2S_UNDERFLOW_CNT_EN adds a saturating
// 16-bit underflow_count output.
module pcm_to_i2s_tx
  import i2s_pkg::*;
#(
  parameter int NUMBER_OF_BITS = DEFAULT_NUMBER_OF_BITS,
  parameter int SLOT_BITS      = DEFAULT_SLOT_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ena,
  pcm_to_i2s_tx_if.slave       pcm,
  output logic                 ws_out,
  output logic                 sd_out,
  output logic                 frame_start,
  output logic                 underflow
`ifdef PCM_TO_I2S_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]          underflow_count
`endif
);

  localparam int KW = clog2(SLOT_BITS);
  localparam int N  = NUMBER_OF_BITS;

  logic [KW-1:0] k_next;
  logic          ws_next;
  logic          load;
  logic          load_ahead;

  // pcm_ready_reg doubles as the "holding register empty" flag.
  logic          pcm_ready_reg;
  logic          pcm_ready_next;
  logic [N-1:0]  hold_left_reg;
  logic [N-1:0]  hold_left_next;
  logic [N-1:0]  hold_right_reg;
  logic [N-1:0]  hold_right_next;
  logic [N-1:0]  frame_left_reg;
  logic [N-1:0]  frame_left_next;
  logic [N-1:0]  frame_right_reg;
  logic [N-1:0]  frame_right_next;
  logic          sd_reg;
  logic          sd_next;
  logic          underflow_reg;
  logic          underflow_next;
  logic          accept;
  logic [N-1:0]  bit_hit;
  logic [N-1:0]  data_sel;

  i2s_frame_timer #(
    .SLOT_BITS (SLOT_BITS),
    .KW        (KW)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .ena         (ena),
    .slot_k_next (k_next),
    .ws_out      (ws_out),
    .ws_out_next (ws_next),
    .frame_start (frame_start),
    .load        (load),
    .load_ahead  (load_ahead)
  );

  assign accept = pcm.pcm_valid && pcm_ready_reg;

  // Holding register: filled on accept, drained by a frame load when full.
  always_comb begin
    pcm_ready_next  = pcm_ready_reg;
    hold_left_next  = hold_left_reg;
    hold_right_next = hold_right_reg;
    if (load && !pcm_ready_reg) begin
      pcm_ready_next = 1'b1;
    end
    if (accept) begin
      pcm_ready_next  = 1'b0;
      hold_left_next  = pcm.pcm_left;
      hold_right_next = pcm.pcm_right;
    end
  end

  // Frame register: takes the held pair at load, or silence when starved.
  always_comb begin
    frame_left_next  = frame_left_reg;
    frame_right_next = frame_right_reg;
    if (load) begin
      if (!pcm_ready_reg) begin
        frame_left_next  = hold_left_reg;
        frame_right_next = hold_right_reg;
      end else begin
        frame_left_next  = '0;
        frame_right_next = '0;
      end
    end
  end

  // One-hot bit select: slot cycle k=1..N maps to bit N-k (MSB at k=1).
  for (genvar gi = 0; gi < N; gi++) begin : g_bit_sel
    assign bit_hit[gi] = (k_next == KW'(N - gi));
  end

  assign data_sel = (ws_next == WS_RIGHT) ? frame_right_reg : frame_left_reg;

  // Serial data and underflow flag are computed for the upcoming cycle so the
  // registered outputs line up with the slot counter. A pair accepted in the
  // load cycle is not seen by that load, matching the look-ahead here.
  always_comb begin
    sd_next        = sd_reg;
    underflow_next = load_ahead && pcm_ready_next;
    if (ena) begin
      sd_next = |(bit_hit & data_sel);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcm_ready_reg   <= 1'b1;
      hold_left_reg   <= '0;
      hold_right_reg  <= '0;
      frame_left_reg  <= '0;
      frame_right_reg <= '0;
      sd_reg          <= 1'b0;
      underflow_reg   <= 1'b0;
    end else begin
      pcm_ready_reg   <= pcm_ready_next;
      hold_left_reg   <= hold_left_next;
      hold_right_reg  <= hold_right_next;
      frame_left_reg  <= frame_left_next;
      frame_right_reg <= frame_right_next;
      sd_reg          <= sd_next;
      underflow_reg   <= underflow_next;
    end
  end

  assign pcm.pcm_ready = pcm_ready_reg;
  assign sd_out        = sd_reg;
  assign underflow     = underflow_reg;

`ifdef PCM_TO_I2S_UNDERFLOW_CNT_EN
  logic [15:0] underflow_count_reg;

  // Saturating count, updated on the same edge that raises underflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      underflow_count_reg <= '0;
    end else if (underflow_next && (underflow_count_reg != 16'hFFFF)) begin
      underflow_count_reg <= underflow_count_reg + 16'd1;
    end
  end

  assign underflow_count = underflow_count_reg;
`endif

endmodule

// File: tb/tb_pcm_to_i2s_tx.sv
// Bench for pcm_to_i2s_tx (N=8, SLOT_BITS=32, 64-cycle frames).
// Cycle 0 is the first cycle after reset release; DUT outputs are sampled on
// the falling edge, inputs are driven on the falling edge.
module tb_pcm_to_i2s_tx;

  typedef struct {
    int         cyc;
    logic       valid;
    logic [7:0] l;
    logic [7:0] r;
    logic       ws;
    logic       sd;
    logic       rdy;
    logic       fs;
    logic       uf;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic ena   = 1'b1;
  logic ws_out;
  logic sd_out;
  logic frame_start;
  logic underflow;
`ifdef PCM_TO_I2S_UNDERFLOW_CNT_EN
  logic [15:0] underflow_count;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic prod_en = 1'b0;

  vec_t        vq[$];
  logic [15:0] tx_q[$];
  logic [15:0] rx_q[$];
  logic [15:0] exp_pairs[100];

  logic        rx_prev;
  int          rx_cnt;
  logic [7:0]  rx_l;
  logic [7:0]  rx_r;

  pcm_to_i2s_tx_if #(.NUMBER_OF_BITS(8)) pcm_if ();

  pcm_to_i2s_tx #(
    .NUMBER_OF_BITS (8),
    .SLOT_BITS      (32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ena         (ena),
    .pcm         (pcm_if),
    .ws_out      (ws_out),
    .sd_out      (sd_out),
    .frame_start (frame_start),
    .underflow   (underflow)
`ifdef PCM_TO_I2S_UNDERFLOW_CNT_EN
    ,
    .underflow_count (underflow_count)
`endif
  );

  always #5 clk = ~clk;

  // Receiver model: realigns on every WS edge, shifts in slot bits k=1..8,
  // emits a {left,right} pair at each return to the left slot. Cycles that
  // follow an ena=0 edge repeat the previous state and are skipped.
  always @(posedge clk) begin
    #2;
    if (reset) begin
      rx_prev <= 1'b0;
      rx_cnt  <= 1;
      rx_l    <= 8'h00;
      rx_r    <= 8'h00;
    end else if (ena) begin
      if (ws_out != rx_prev) begin
        rx_prev <= ws_out;
        rx_cnt  <= 1;
        if (!ws_out) rx_q.push_back({rx_l, rx_r});
      end else begin
        if (rx_cnt >= 1 && rx_cnt <= 8) begin
          if (ws_out) rx_r <= {rx_r[6:0], sd_out};
          else        rx_l <= {rx_l[6:0], sd_out};
        end
        rx_cnt <= rx_cnt + 1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_producer();
    if (tx_q.size() > 0) begin
      pcm_if.pcm_valid = 1'b1;
      pcm_if.pcm_left  = tx_q[0][15:8];
      pcm_if.pcm_right = tx_q[0][7:0];
      if (pcm_if.pcm_ready) tx_q.delete(0);
    end else begin
      pcm_if.pcm_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (prod_en) drive_producer();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    ena   = 1'b1;
    prod_en = 1'b0;
    pcm_if.pcm_valid = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    rx_q.delete();
  endtask

  task automatic add(input int c, input logic v, input logic [7:0] l, input logic [7:0] r,
                     input logic ws, input logic sd, input logic rdy, input logic fs, input logic uf);
    vec_t e;
    e.cyc = c; e.valid = v; e.l = l; e.r = r;
    e.ws = ws; e.sd = sd; e.rdy = rdy; e.fs = fs; e.uf = uf;
    vq.push_back(e);
  endtask

  function automatic logic [15:0] rx_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 16'hxxxx;
  endfunction

  initial begin
    logic [7:0] lbits;
    logic [7:0] rbits;
    logic       any_one;
    pcm_if.pcm_valid = 1'b0;
    pcm_if.pcm_left  = 8'h00;
    pcm_if.pcm_right = 8'h00;

    // ---- Reset values and first data frame (L=A5, R=3C), table driven ----
    lbits = 8'b1010_0101;
    rbits = 8'b0011_1100;
    add(0,   1'b1, 8'hA5, 8'h3C, 0, 0, 1, 0, 0);
    add(1,   1'b0, 8'h00, 8'h00, 0, 0, 0, 0, 0);
    add(62,  1'b0, 8'h00, 8'h00, 1, 0, 0, 0, 0);
    add(63,  1'b0, 8'h00, 8'h00, 1, 0, 0, 0, 0);
    add(64,  1'b0, 8'h00, 8'h00, 0, 0, 1, 1, 0);
    for (int i = 0; i < 8; i++) add(65 + i, 1'b0, 8'h00, 8'h00, 0, lbits[7-i], 1, 0, 0);
    add(73,  1'b0, 8'h00, 8'h00, 0, 0, 1, 0, 0);
    add(95,  1'b0, 8'h00, 8'h00, 0, 0, 1, 0, 0);
    add(96,  1'b0, 8'h00, 8'h00, 1, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) add(97 + i, 1'b0, 8'h00, 8'h00, 1, rbits[7-i], 1, 0, 0);
    add(105, 1'b0, 8'h00, 8'h00, 1, 0, 1, 0, 0);
    add(126, 1'b0, 8'h00, 8'h00, 1, 0, 1, 0, 0);
    add(127, 1'b0, 8'h00, 8'h00, 1, 0, 1, 0, 1);
    add(128, 1'b0, 8'h00, 8'h00, 0, 0, 1, 1, 0);
    add(129, 1'b0, 8'h00, 8'h00, 0, 0, 1, 0, 0);
    add(136, 1'b0, 8'h00, 8'h00, 0, 0, 1, 0, 0);

    do_reset(3);
    for (int i = 0; i < vq.size(); i++) begin
      run_to(vq[i].cyc);
      $display("vec %0d cycle %0d: ws=%b sd=%b rdy=%b fs=%b uf=%b", i, cyc,
               ws_out, sd_out, pcm_if.pcm_ready, frame_start, underflow);
      check("vec_ws",    ws_out,           vq[i].ws);
      check("vec_sd",    sd_out,           vq[i].sd);
      check("vec_ready", pcm_if.pcm_ready, vq[i].rdy);
      check("vec_fs",    frame_start,      vq[i].fs);
      check("vec_uf",    underflow,        vq[i].uf);
      pcm_if.pcm_valid = vq[i].valid;
      pcm_if.pcm_left  = vq[i].l;
      pcm_if.pcm_right = vq[i].r;
    end

    // ---- Underflow: starved from reset ----
    do_reset(2);
    run_to(62);
    check("uf_before", underflow, 1'b0);
    run_to(63);
    check("uf_pulse", underflow, 1'b1);
`ifdef PCM_TO_I2S_UNDERFLOW_CNT_EN
    check("uf_count1", underflow_count, 16'd1);
`endif
    run_to(64);
    check("uf_after", underflow, 1'b0);
    check("uf_fs", frame_start, 1'b1);
    any_one = 1'b0;
    for (int c = 64; c < 128; c++) begin
      run_to(c);
      any_one = any_one | sd_out;
    end
    check("uf_zero_frame", any_one, 1'b0);
    run_to(191);
    check("uf_pulse3", underflow, 1'b1);
`ifdef PCM_TO_I2S_UNDERFLOW_CNT_EN
    check("uf_count3", underflow_count, 16'd3);
`endif
    $display("underflow sequence done at cycle %0d", cyc);

    // ---- Backpressure: valid held high with three pairs ----
    do_reset(2);
    tx_q.push_back(16'h11EE);
    tx_q.push_back(16'h22DD);
    tx_q.push_back(16'h33CC);
    prod_en = 1'b1;
    drive_producer();
    run_to(1);   check("bp_ready_c1",   pcm_if.pcm_ready, 1'b0);
    run_to(63);  check("bp_ready_c63",  pcm_if.pcm_ready, 1'b0);
    run_to(64);  check("bp_ready_c64",  pcm_if.pcm_ready, 1'b1);
    run_to(65);  check("bp_ready_c65",  pcm_if.pcm_ready, 1'b0);
    run_to(127); check("bp_ready_c127", pcm_if.pcm_ready, 1'b0);
    run_to(128); check("bp_ready_c128", pcm_if.pcm_ready, 1'b1);
    run_to(260);
    check("bp_frame0", rx_at(0), 16'h0000);
    check("bp_frame1", rx_at(1), 16'h11EE);
    check("bp_frame2", rx_at(2), 16'h22DD);
    check("bp_frame3", rx_at(3), 16'h33CC);
    $display("backpressure sequence: %0d frames received", rx_q.size());

    // ---- Reset mid left slot with the holding register full ----
    do_reset(2);
    tx_q.push_back(16'hC381);
    tx_q.push_back(16'h7E18);
    prod_en = 1'b1;
    drive_producer();
    run_to(66);
    check("rst_hold_full", pcm_if.pcm_ready, 1'b0);
    run_to(69);
    check("rst_ws_k5", ws_out, 1'b0);
    reset   = 1'b1;
    prod_en = 1'b0;
    pcm_if.pcm_valid = 1'b0;
    tick();
    check("rst_ws",    ws_out,           1'b0);
    check("rst_sd",    sd_out,           1'b0);
    check("rst_ready", pcm_if.pcm_ready, 1'b1);
    check("rst_fs",    frame_start,      1'b0);
    check("rst_uf",    underflow,        1'b0);
    reset = 1'b0;
    cyc   = 0;
    rx_q.delete();
    run_to(63);
    check("rst_pair_dropped", underflow, 1'b1);
    run_to(130);
    check("rst_frame0", rx_at(0), 16'h0000);
    check("rst_frame1", rx_at(1), 16'h0000);
    $display("mid-frame reset sequence done");

    // ---- Loopback of 100 random pairs with a 10-cycle ena gap ----
    do_reset(2);
    for (int i = 0; i < 100; i++) begin
      exp_pairs[i] = 16'($urandom);
      tx_q.push_back(exp_pairs[i]);
    end
    prod_en = 1'b1;
    drive_producer();
    while (rx_q.size() < 101 && cyc < 8000) begin
      tick();
      if (cyc >= 355 && cyc <= 365) begin
        // frame 5 carries pair 4; right slot k=3 drives right bit 5
        check("ena_hold_ws", ws_out, 1'b1);
        check("ena_hold_sd", sd_out, exp_pairs[4][5]);
      end
      if (cyc == 355) ena = 1'b0;
      if (cyc == 365) ena = 1'b1;
    end
    check("loop_frames", (rx_q.size() >= 101), 1'b1);
    check("loop_frame0", rx_at(0), 16'h0000);
    for (int i = 0; i < 100; i++) begin
      $display("pair %0d: sent L=%h R=%h received L=%h R=%h", i,
               exp_pairs[i][15:8], exp_pairs[i][7:0], rx_at(i + 1) >> 8, rx_at(i + 1) & 16'h00FF);
      check("loop_pair", rx_at(i + 1), exp_pairs[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
